// File: rtl/alu_md_unit.sv
// alu_md_unit: ALU control decode plus an iterative multiply/divide engine.
// The decode half is purely combinational. The mul/div half launches an
// operation from IDLE, runs one bit per cycle for XLEN cycles in CALC and
// presents a registered result with a one-cycle done pulse in DONE.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start with an M-extension instruction
// CALC  | one shift-add / restoring-divide step per cycle, XLEN cycles
// DONE  | result registered, done pulsed, returns to IDLE next cycle
module alu_md_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            opb5,
    input  logic            start,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [3:0]      ALUControl,
    output logic            md_sel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q;
    logic            neg_q, rneg_q, div0_q;

    logic            accept;
    logic            last_step;
    logic            busy_d, done_d;

    logic            a_signed, b_signed, a_neg, b_neg, is_div;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] hi_step, lo_step;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   result_d;

    // ALU control decode from the main decoder class and funct fields
    always_comb begin
        ALUControl = 4'b0000;
        case (ALUOp)
            2'b00:   ALUControl = 4'b0000;
            2'b01:   ALUControl = 4'b0001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & opb5) ? 4'b0001 : 4'b0000;
                    3'b001:  ALUControl = 4'b0011;
                    3'b010:  ALUControl = 4'b0100;
                    3'b011:  ALUControl = 4'b0101;
                    3'b100:  ALUControl = 4'b0110;
                    3'b101:  ALUControl = funct7b5 ? 4'b0111 : 4'b1000;
                    3'b110:  ALUControl = 4'b1001;
                    default: ALUControl = 4'b1010;
                endcase
            end
        endcase
    end

    assign md_sel    = (ALUOp == 2'b10) & opb5 & funct7b0;
    assign accept    = (state_q == S_IDLE) & start & md_sel;
    assign last_step = (state_q == S_CALC) && (cnt_q == '0);

    // Operand sign handling on the live inputs, captured only on the accepting edge
    always_comb begin
        a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) |
                   (funct3 == 3'b100) | (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        a_neg    = a_signed & srcA[XLEN-1];
        b_neg    = b_signed & srcB[XLEN-1];
        a_mag    = a_neg ? (~srcA + 1'b1) : srcA;
        b_mag    = b_neg ? (~srcB + 1'b1) : srcB;
        is_div   = funct3[2];
    end

    // One iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        if (f3_q[2]) begin
            hi_step = div_ge ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection applied to the final iteration
    always_comb begin
        prod_fix = neg_q ? (~{hi_step, lo_step} + 1'b1) : {hi_step, lo_step};
        if (div0_q)
            quo_fix = '1;
        else
            quo_fix = neg_q ? (~lo_step + 1'b1) : lo_step;
        rem_fix = rneg_q ? (~hi_step + 1'b1) : hi_step;
        case (f3_q)
            3'b000:          result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:  result_d = quo_fix;
            default:         result_d = rem_fix;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered below so busy/done come straight from flops
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Registered status flags and result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            md_result <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (last_step)
                md_result <= result_d;
        end
    end

    // Iteration counter: loaded on accept, terminal count at zero ends CALC
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= CW'(XLEN - 1);
        else if (state_q == S_CALC)
            cnt_q <= cnt_q - 1'b1;
    end

    // Operand capture on accept and working registers during CALC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
        end else if (accept) begin
            f3_q   <= funct3;
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            opnd_q <= is_div ? b_mag : a_mag;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            div0_q <= (srcB == '0);
        end else if (state_q == S_CALC) begin
            hi_q <= hi_step;
            lo_q <= lo_step;
        end
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// Scoreboard bench for alu_md_unit: directed decode checks plus queued
// mul/div transactions checked for value and done latency by a monitor.
module tb_alu_md_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic            funct7b5, funct7b0, opb5, start;
    logic [XLEN-1:0] srcA, srcB;
    logic [3:0]      ALUControl;
    logic            md_sel, busy, done;
    logic [XLEN-1:0] md_result;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;

    logic [XLEN-1:0] exp_q[$];
    int              acc_q[$];
    string           name_q[$];
    logic [XLEN-1:0] last_res = '0;

    alu_md_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .funct3(funct3),
        .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5), .start(start),
        .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .md_sel(md_sel),
        .busy(busy), .done(done), .md_result(md_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented
    always @(negedge clk) begin
        if (reset) begin
            last_res = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 result %h expected no done", md_result);
            end else begin
                automatic string nm = name_q.pop_front();
                automatic int    acc = acc_q.pop_front();
                check({nm, "_result"}, md_result, exp_q.pop_front());
                check({nm, "_latency"}, XLEN'(edge_cnt + 1 - acc), XLEN'(XLEN + 1));
            end
            last_res = md_result;
        end else begin
            check("result_hold", md_result, last_res);
        end
    end

    // Called at a negedge: drives one request, which the next edge accepts
    task automatic issue(input string nm, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input bit track);
        ALUOp = 2'b10; opb5 = 1'b1; funct7b0 = 1'b1; funct7b5 = 1'b0;
        funct3 = f3; srcA = a; srcB = b; start = 1'b1;
        if (track) begin
            exp_q.push_back(exp);
            acc_q.push_back(edge_cnt + 1);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        srcA = ~a; srcB = ~b; funct3 = ~f3;
        check({nm, "_busy"}, XLEN'(busy), XLEN'(1));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
            exp_q.delete(); acc_q.delete(); name_q.delete();
        end
    endtask

    task automatic chk_alu(input string nm, input logic [1:0] op, input logic [2:0] f3,
                           input logic f7b5, input logic ob5, input logic f7b0,
                           input logic [3:0] exp_ctl, input logic exp_sel);
        ALUOp = op; funct3 = f3; funct7b5 = f7b5; opb5 = ob5; funct7b0 = f7b0;
        #1;
        check({nm, "_ctl"}, XLEN'(ALUControl), XLEN'(exp_ctl));
        check({nm, "_sel"}, XLEN'(md_sel), XLEN'(exp_sel));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ALUOp = 2'b00; funct3 = 3'b000;
        funct7b5 = 1'b0; funct7b0 = 1'b0; opb5 = 1'b0; srcA = '0; srcB = '0;
        #12;
        check("rst_busy", XLEN'(busy), '0);
        check("rst_done", XLEN'(done), '0);
        check("rst_result", md_result, '0);
        @(negedge clk);
        reset = 1'b0;

        chk_alu("alu_op00",   2'b00, 3'b111, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_alu("alu_op01",   2'b01, 3'b101, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0);
        chk_alu("alu_sub",    2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0);
        chk_alu("alu_addi",   2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk_alu("alu_sll",    2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0);
        chk_alu("alu_slt",    2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0);
        chk_alu("alu_sltu",   2'b10, 3'b011, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
        chk_alu("alu_xor",    2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0);
        chk_alu("alu_sra",    2'b10, 3'b101, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0);
        chk_alu("alu_srl",    2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0);
        chk_alu("alu_or",     2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b0);
        chk_alu("alu_and",    2'b11, 3'b111, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0);
        chk_alu("alu_mdsel",  2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b1);
        chk_alu("alu_mdimm",  2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);

        // start with md_sel=0 must not launch anything
        @(negedge clk);
        ALUOp = 2'b00; opb5 = 1'b1; funct7b0 = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("nosel_busy", XLEN'(busy), '0);
        @(negedge clk);

        issue("mul_7",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1); wait_idle();
        issue("mulhu_ff",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1); wait_idle();
        issue("mulh_ff",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1); wait_idle();
        issue("mulhsu_ff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); wait_idle();
        issue("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1); wait_idle();
        issue("mul_shift",  3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b1); wait_idle();
        issue("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1); wait_idle();
        issue("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1); wait_idle();
        issue("divu_z",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1); wait_idle();
        issue("remu_z",     3'b111, 32'd5,        32'd0,        32'd5,        1'b1); wait_idle();
        issue("div_m7",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1); wait_idle();
        issue("rem_m7",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b1); wait_idle();
        issue("div_m7z",    3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1); wait_idle();
        issue("rem_m7z",    3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1); wait_idle();

        // A second start mid-operation must be ignored
        issue("ign_mulhu",  3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 1'b1);
        repeat (9) @(negedge clk);
        funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", XLEN'(busy), XLEN'(1));
        wait_idle();

        // Reset mid-CALC aborts with no done pulse
        issue("abort",      3'b101, 32'h0000FFFF, 32'd3, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", XLEN'(busy), '0);
        check("abort_done", XLEN'(done), '0);
        check("abort_result", md_result, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue("divu_100_7", 3'b101, 32'd100,      32'd7,        32'd14,       1'b1); wait_idle();
        issue("remu_100_7", 3'b111, 32'd100,      32'd7,        32'd2,        1'b1); wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
